fir_ram_sequencer: RTL and testbench

Controller in front of ReConf_FirFilter that owns the filter's coefficient-RAM control pins (iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWtDtRam).
- Runs coefficient-update transactions fed by a host valid/ready stream.
- Runs one NUM_TAPS-long read sweep per 600 kHz sample strobe.
- Arbitrates between update and read sweep so the RAM never sees both at once.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_seq_addr_cnt.sv | 30 +++
 rtl/fir_ram_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_fir_ram_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and default sizing for the FIR coefficient-RAM
// sequencer. Optional build macro used by the sequencer: FIR_SEQ_CKSUM_EN.
package fir_pkg;

  localparam int DEF_NUM_TAPS  = 11;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 16;
  // Clocks between 600 kHz sample strobes at 12 MHz.
  localparam int SAMPLE_PERIOD = 20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SWEEP  = 3'd1,
    UPD_SETUP = 3'd2,
    UPD_WRITE = 3'd3,
    UPD_HOLD  = 3'd4
  } seqState_t;

  function automatic logic isUpdState(input seqState_t s);
    return (s == UPD_SETUP) || (s == UPD_WRITE) || (s == UPD_HOLD);
  endfunction

endpackage

// File: rtl/fir_seq_addr_cnt.sv
// fir_seq_addr_cnt: tap counter shared by the read sweep and the write path.
// Holds the next tap index; oLast flags the final tap, oDone a complete set.
module fir_seq_addr_cnt #(
  parameter int MAX_CNT = 11,
  parameter int CNT_W   = 4
) (
  input  logic             iClk12M,
  input  logic             iRsn,
  input  logic             iClr,
  input  logic             iInc,
  output logic [CNT_W-1:0] oCnt,
  output logic             oLast,
  output logic             oDone
);

  // Clear has priority; counting stops at MAX_CNT.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      oCnt <= '0;
    end else if (iClr) begin
      oCnt <= '0;
    end else if (iInc && !oDone) begin
      oCnt <= oCnt + CNT_W'(1);
    end
  end

  assign oLast = (oCnt == CNT_W'(MAX_CNT - 1));
  assign oDone = (oCnt == CNT_W'(MAX_CNT));

endmodule

// File: rtl/fir_ram_sequencer.sv
// fir_ram_sequencer: owns the ReConf_FirFilter coefficient-RAM pins, running
// one read sweep per sample strobe and host-fed coefficient updates, never both
// at once. Build macro FIR_SEQ_CKSUM_EN enables the coefficient checksum.
module fir_ram_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = DEF_NUM_TAPS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GUARD_CYC = 2,
  parameter int MISS_W    = 8
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic              iUpdReq,
  input  logic              iCoeffVld,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffRdy,
  output logic              oCoeffUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic              oRdLast,
  output logic              oUpdDone,
  output logic              oBusy,
  output logic [MISS_W-1:0] oMissCnt,
  output logic [DATA_W-1:0] oCoeffCksum
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam int GRD_W = $clog2(GUARD_CYC + 1);

  seqState_t         state;
  seqState_t         nState;
  logic [CNT_W-1:0]  tapCnt;
  logic              tapLast;
  logic              tapDone;
  logic              tapClr;
  logic              tapInc;
  logic [GRD_W-1:0]  grdCnt;
  logic [GRD_W-1:0]  grdCntNxt;
  logic              pending;
  logic              pendingNxt;
  logic              accept;
  logic              missInc;
  logic              csnNxt;
  logic              wrnNxt;
  logic              flagNxt;
  logic              rdLastNxt;
  logic              updDoneNxt;
  logic [ADDR_W-1:0] addrNxt;
  logic [DATA_W-1:0] wtDtNxt;

  fir_seq_addr_cnt #(
    .MAX_CNT (NUM_TAPS),
    .CNT_W   (CNT_W)
  ) uTapCnt (
    .iClk12M (iClk12M),
    .iRsn    (iRsn),
    .iClr    (tapClr),
    .iInc    (tapInc),
    .oCnt    (tapCnt),
    .oLast   (tapLast),
    .oDone   (tapDone)
  );

  assign oCoeffRdy = (state == UPD_WRITE) && !tapDone;
  assign accept    = oCoeffRdy && iCoeffVld;
  assign missInc   = iEnSample600k && (state != IDLE);
  assign oBusy     = (state != IDLE);

  // State and registered RAM-side outputs.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state            <= IDLE;
      grdCnt           <= '0;
      pending          <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oCoeffUpdateFlag <= 1'b0;
      oAddrRam         <= '0;
      oWtDtRam         <= '0;
      oRdLast          <= 1'b0;
      oUpdDone         <= 1'b0;
    end else begin
      state            <= nState;
      grdCnt           <= grdCntNxt;
      pending          <= pendingNxt;
      oCsnRam          <= csnNxt;
      oWrnRam          <= wrnNxt;
      oCoeffUpdateFlag <= flagNxt;
      oAddrRam         <= addrNxt;
      oWtDtRam         <= wtDtNxt;
      oRdLast          <= rdLastNxt;
      oUpdDone         <= updDoneNxt;
    end
  end

  // Next-state and next RAM-pin values; the sweep issues the counter value as
  // the address, so the first address leaves on the edge that leaves IDLE.
  always_comb begin
    nState     = state;
    grdCntNxt  = grdCnt;
    pendingNxt = pending;
    tapClr     = 1'b0;
    tapInc     = 1'b0;
    csnNxt     = 1'b1;
    wrnNxt     = 1'b1;
    rdLastNxt  = 1'b0;
    updDoneNxt = 1'b0;
    addrNxt    = oAddrRam;
    wtDtNxt    = oWtDtRam;

    case (state)
      IDLE: begin
        if (iEnSample600k) begin
          nState    = RD_SWEEP;
          csnNxt    = 1'b0;
          addrNxt   = ADDR_W'(tapCnt);
          rdLastNxt = tapLast;
          tapInc    = 1'b1;
          if (iUpdReq) begin
            pendingNxt = 1'b1;
          end
        end else if (pending || iUpdReq) begin
          nState = UPD_SETUP;
          tapClr = 1'b1;
        end else begin
          tapClr = 1'b1;
        end
      end

      RD_SWEEP: begin
        if (iUpdReq) begin
          pendingNxt = 1'b1;
        end
        if (tapDone) begin
          tapClr = 1'b1;
          // A pended update starts as the sweep releases the RAM, skipping
          // the IDLE cycle it would otherwise spend there.
          if (pending || iUpdReq) begin
            nState = UPD_SETUP;
          end else begin
            nState = IDLE;
          end
        end else begin
          csnNxt    = 1'b0;
          addrNxt   = ADDR_W'(tapCnt);
          rdLastNxt = tapLast;
          tapInc    = 1'b1;
        end
      end

      UPD_SETUP: begin
        tapClr    = 1'b1;
        grdCntNxt = '0;
        nState    = UPD_WRITE;
      end

      UPD_WRITE: begin
        if (accept) begin
          csnNxt  = 1'b0;
          wrnNxt  = 1'b0;
          addrNxt = ADDR_W'(tapCnt);
          wtDtNxt = iCoeffData;
          tapInc  = 1'b1;
          if (tapLast) begin
            nState    = UPD_HOLD;
            grdCntNxt = '0;
          end
        end
      end

      UPD_HOLD: begin
        if (grdCnt == GRD_W'(GUARD_CYC - 1)) begin
          nState     = IDLE;
          updDoneNxt = 1'b1;
          pendingNxt = 1'b0;
          tapClr     = 1'b1;
        end else begin
          grdCntNxt = grdCnt + GRD_W'(1);
        end
      end

      default: begin
        nState = IDLE;
        tapClr = 1'b1;
      end
    endcase

    flagNxt = isUpdState(nState);
  end

  // Saturating count of sample strobes that could not get a sweep.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      oMissCnt <= '0;
    end else if (missInc && (oMissCnt != '1)) begin
      oMissCnt <= oMissCnt + MISS_W'(1);
    end
  end

`ifdef FIR_SEQ_CKSUM_EN
  logic [DATA_W-1:0] cksum;

  // Running sum of the accepted coefficients of the current set.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      cksum <= '0;
    end else if (state == UPD_SETUP) begin
      cksum <= '0;
    end else if (accept) begin
      cksum <= cksum + iCoeffData;
    end
  end

  assign oCoeffCksum = cksum;
`else
  assign oCoeffCksum = '0;
`endif

endmodule

// File: tb/tb_fir_ram_sequencer.sv
// tb_fir_ram_sequencer: directed and randomized checks of fir_ram_sequencer
// against a transaction-level expectation of sweeps, updates and misses.
module tb_fir_ram_sequencer;
  import fir_pkg::*;

  localparam int NT    = 11;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int GUARD = 2;
  localparam int MW    = 8;

  logic          iClk12M = 1'b0;
  logic          iRsn = 1'b0;
  logic          iEnSample600k = 1'b0;
  logic          iUpdReq = 1'b0;
  logic          iCoeffVld = 1'b0;
  logic [DW-1:0] iCoeffData = '0;
  logic          oCoeffRdy;
  logic          oCoeffUpdateFlag;
  logic          oCsnRam;
  logic          oWrnRam;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWtDtRam;
  logic          oRdLast;
  logic          oUpdDone;
  logic          oBusy;
  logic [MW-1:0] oMissCnt;
  logic [DW-1:0] oCoeffCksum;

  fir_ram_sequencer #(
    .NUM_TAPS  (NT),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .GUARD_CYC (GUARD),
    .MISS_W    (MW)
  ) dut (
    .iClk12M          (iClk12M),
    .iRsn             (iRsn),
    .iEnSample600k    (iEnSample600k),
    .iUpdReq          (iUpdReq),
    .iCoeffVld        (iCoeffVld),
    .iCoeffData       (iCoeffData),
    .oCoeffRdy        (oCoeffRdy),
    .oCoeffUpdateFlag (oCoeffUpdateFlag),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWtDtRam         (oWtDtRam),
    .oRdLast          (oRdLast),
    .oUpdDone         (oUpdDone),
    .oBusy            (oBusy),
    .oMissCnt         (oMissCnt),
    .oCoeffCksum      (oCoeffCksum)
  );

  always #5 iClk12M = ~iClk12M;

  int total = 0;
  int bad = 0;
  int expMiss = 0;

  // Transaction monitor state.
  int cycNo = 0;
  int rdQ[$];
  int wrAddrQ[$];
  logic [DW-1:0] wrDataQ[$];
  int flagCyc = 0;
  int firstFlagCyc = -1;
  int doneCnt = 0;
  int doneCyc = -1;
  int rdDuringUpd = 0;
  int wrOutsideFlag = 0;
  logic flagPrev = 1'b0;

  logic [DW-1:0] coef [NT];

  always @(posedge iClk12M) cycNo <= cycNo + 1;

  always @(negedge iClk12M) begin
    if (iRsn) begin
      if (!oCsnRam && oWrnRam) begin
        rdQ.push_back(int'(oAddrRam));
        if (oCoeffUpdateFlag) rdDuringUpd++;
      end
      if (!oCsnRam && !oWrnRam) begin
        wrAddrQ.push_back(int'(oAddrRam));
        wrDataQ.push_back(oWtDtRam);
        if (!oCoeffUpdateFlag) wrOutsideFlag++;
      end
      if (oCoeffUpdateFlag) flagCyc++;
      if (oCoeffUpdateFlag && !flagPrev) firstFlagCyc = cycNo;
      flagPrev = oCoeffUpdateFlag;
      if (oUpdDone) begin
        doneCnt++;
        doneCyc = cycNo;
      end
    end else begin
      flagPrev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  task automatic clearMon();
    rdQ.delete();
    wrAddrQ.delete();
    wrDataQ.delete();
    flagCyc = 0;
    firstFlagCyc = -1;
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_csn"},   oCsnRam, 1);
    chk({tag, "_wrn"},   oWrnRam, 1);
    chk({tag, "_flag"},  oCoeffUpdateFlag, 0);
    chk({tag, "_addr"},  oAddrRam, 0);
    chk({tag, "_data"},  oWtDtRam, 0);
    chk({tag, "_rdy"},   oCoeffRdy, 0);
    chk({tag, "_last"},  oRdLast, 0);
    chk({tag, "_done"},  oUpdDone, 0);
    chk({tag, "_busy"},  oBusy, 0);
    chk({tag, "_miss"},  oMissCnt, 0);
    chk({tag, "_cksum"}, oCoeffCksum, 0);
  endtask

  // One strobe from idle: expect NT read cycles at addresses 0..NT-1.
  task automatic doSweep(input string tag);
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    for (int k = 0; k < NT; k++) begin
      @(negedge iClk12M);
      chk({tag, "_csn"},  oCsnRam, 0);
      chk({tag, "_wrn"},  oWrnRam, 1);
      chk({tag, "_addr"}, oAddrRam, k);
      chk({tag, "_last"}, oRdLast, (k == NT - 1));
    end
    @(negedge iClk12M);
    chk({tag, "_release"}, oCsnRam, 1);
    chk({tag, "_miss"}, oMissCnt, expMiss);
    tick();
  endtask

  // Full update of coef[]; optional host stall after stallAt beats with
  // strobes (every other stall cycle) and an ignored request inside the stall.
  task automatic doUpdate(input string tag, input int stallAt, input int stallLen,
                          input int strobes, input bit reqInStall, input bit withStrobe);
    int d0;
    int r;
    int acc;
    int cyc;
    int st;
    int wait0;
    logic [DW-1:0] sum;
    clearMon();
    d0 = doneCnt;
    iUpdReq = 1'b1;
    iEnSample600k = withStrobe;
    @(negedge iClk12M);
    r = cycNo;
    tick();
    iUpdReq = 1'b0;
    iEnSample600k = 1'b0;
    acc = 0;
    cyc = 0;
    st = 0;
    while (acc < NT && cyc < 2000) begin
      if (stallLen > 0 && acc == stallAt && st < stallLen) begin
        iCoeffVld = 1'b0;
        iEnSample600k = (st % 2 == 0) && (st / 2 < strobes);
        iUpdReq = reqInStall && (st == 1);
        st++;
      end else begin
        iCoeffVld = 1'b1;
        iCoeffData = coef[acc];
        iEnSample600k = 1'b0;
        iUpdReq = 1'b0;
      end
      @(negedge iClk12M);
      if (iCoeffVld && oCoeffRdy) acc++;
      tick();
      cyc++;
    end
    iCoeffVld = 1'b0;
    iEnSample600k = 1'b0;
    iUpdReq = 1'b0;
    chk({tag, "_beats"}, acc, NT);
    wait0 = 0;
    while (doneCnt == d0 && wait0 < 100) begin
      @(negedge iClk12M);
      wait0++;
    end
    chk({tag, "_done_seen"}, doneCnt, d0 + 1);
    if (withStrobe) begin
      chk({tag, "_setup_after_sweep"}, firstFlagCyc, r + NT + 1);
      chk({tag, "_sweep_len"}, rdQ.size(), NT);
      for (int k = 0; k < NT && k < rdQ.size(); k++) chk({tag, "_sweep_addr"}, rdQ[k], k);
    end else begin
      chk({tag, "_latency"}, doneCyc - r, 2 + NT + GUARD + stallLen);
      chk({tag, "_no_reads"}, rdQ.size(), 0);
    end
    chk({tag, "_flag_cycles"}, flagCyc, 1 + NT + GUARD + stallLen);
    chk({tag, "_wr_count"}, wrAddrQ.size(), NT);
    sum = '0;
    for (int k = 0; k < NT; k++) sum = sum + coef[k];
    for (int k = 0; k < NT && k < wrAddrQ.size(); k++) begin
      chk({tag, "_wr_addr"}, wrAddrQ[k], k);
      chk({tag, "_wr_data"}, wrDataQ[k], coef[k]);
    end
`ifdef FIR_SEQ_CKSUM_EN
    chk({tag, "_cksum"}, oCoeffCksum, sum);
`else
    chk({tag, "_cksum"}, oCoeffCksum, 0);
`endif
    repeat (4) tick();
    chk({tag, "_idle_busy"}, oBusy, 0);
    chk({tag, "_idle_flag"}, oCoeffUpdateFlag, 0);
    chk({tag, "_single_done"}, doneCnt, d0 + 1);
    expMiss = (expMiss + strobes > 255) ? 255 : expMiss + strobes;
    chk({tag, "_miss"}, oMissCnt, expMiss);
  endtask

  task automatic randCoef();
    for (int k = 0; k < NT; k++) coef[k] = DW'($urandom);
  endtask

  task automatic specCoef();
    coef[0] = 16'h000C; coef[1] = 16'h0000; coef[2]  = 16'h0013; coef[3] = 16'h0017;
    coef[4] = 16'h0000; coef[5] = 16'h0024; coef[6]  = 16'h0030; coef[7] = 16'h0000;
    coef[8] = 16'h0065; coef[9] = 16'h00CD; coef[10] = 16'h01F3;
  endtask

  initial begin
    int guard;
    bit hit;
    repeat (3) @(posedge iClk12M);
    #1;
    checkResetVals("reset");
    iRsn = 1'b1;
    repeat (3) tick();

    doSweep("sweep0");
    repeat (SAMPLE_PERIOD - NT - 2) tick();
    doSweep("sweep1");

    specCoef();
    doUpdate("upd", -1, 0, 0, 1'b0, 1'b0);
    doUpdate("stall", 4, 3, 0, 1'b0, 1'b0);

    randCoef();
    doUpdate("same_cycle", -1, 0, 0, 1'b0, 1'b1);

    randCoef();
    doUpdate("miss2", int'($urandom_range(1, 9)), 4, 2, 1'b1, 1'b0);

    randCoef();
    doUpdate("saturate", 3, 600, 300, 1'b0, 1'b0);

    // Reset asserted just after the 5th coefficient write is on the pins.
    randCoef();
    iUpdReq = 1'b1;
    tick();
    iUpdReq = 1'b0;
    guard = 0;
    hit = 1'b0;
    while (!hit && guard < 100) begin
      iCoeffVld = 1'b1;
      iCoeffData = coef[guard % NT];
      @(negedge iClk12M);
      if (!oCsnRam && !oWrnRam && oAddrRam == AW'(4)) begin
        hit = 1'b1;
      end else begin
        tick();
        guard++;
      end
    end
    chk("midreset_reached_5th", hit, 1);
    iRsn = 1'b0;
    #1;
    iCoeffVld = 1'b0;
    checkResetVals("midreset");
    expMiss = 0;
    repeat (2) tick();
    iRsn = 1'b1;
    tick();

    randCoef();
    doUpdate("after_reset", int'($urandom_range(1, 10)), int'($urandom_range(1, 5)), 0, 1'b0, 1'b0);
    doSweep("sweep2");

    chk("no_read_under_flag", rdDuringUpd, 0);
    chk("no_write_outside_flag", wrOutsideFlag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
